// File: rtl/filter2d_pkg.sv
// Shared types and constants for the filter2d sequencer: FSM encoding, weight bank size,
// config address map and a counter-width helper.
package filter2d_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int         NUM_WEIGHTS   = 9;
   localparam logic [3:0] CFG_ADDR_MODE = 4'd9;

   // Bits needed to count 0..n-1; never less than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/filter2d_ctrl_wbank.sv
// Shadow weight bank: 9 weights plus the mode bit, written from the config port at any time,
// read back by address during LOAD. The dirty flag records writes made since the last LOAD.
module filter2d_ctrl_wbank
   import filter2d_pkg::*;
#(
   parameter int BITWIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [3:0]          cfg_addr,
   input  logic [BITWIDTH-1:0] cfg_wdata,
   input  logic [3:0]          rd_addr,
   input  logic                clr_dirty,
   output logic [BITWIDTH-1:0] rd_data,
   output logic                mode,
   output logic                dirty
);

   logic [NUM_WEIGHTS-1:0][BITWIDTH-1:0] wgt_q, wgt_d;
   logic                                 mode_q, mode_d;
   logic                                 dirty_q, dirty_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wgt_q   <= '0;
         mode_q  <= 1'b0;
         dirty_q <= 1'b0;
      end else begin
         wgt_q   <= wgt_d;
         mode_q  <= mode_d;
         dirty_q <= dirty_d;
      end
   end

   // A write landing in the same cycle as the clear keeps the bank dirty.
   always_comb begin
      wgt_d   = wgt_q;
      mode_d  = mode_q;
      dirty_d = dirty_q & ~clr_dirty;
      if (cfg_we) begin
         for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (cfg_addr == 4'(i)) begin
               wgt_d[i] = cfg_wdata;
               dirty_d  = 1'b1;
            end
         end
         if (cfg_addr == CFG_ADDR_MODE) begin
            mode_d  = cfg_wdata[0];
            dirty_d = 1'b1;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_WEIGHTS; i++) begin
         if (rd_addr == 4'(i)) rd_data = wgt_q[i];
      end
   end

   assign mode  = mode_q;
   assign dirty = dirty_q;

endmodule

// File: rtl/filter2d_ctrl.sv
// Frame sequencer for the 3x3 filter2d PE: replays shadow weights, streams COLS*ROWS pixels,
// drains the PE and signals completion. FILTER2D_CTRL_CONT_EN selects continuous frame mode.
module filter2d_ctrl
   import filter2d_pkg::*;
#(
   parameter int BITWIDTH  = 8,
   parameter int COLS      = 640,
   parameter int ROWS      = 480,
   parameter int DRAIN_CYC = 64,
   parameter int PIX_GAP   = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [3:0]          cfg_addr,
   input  logic [BITWIDTH-1:0] cfg_wdata,
   input  logic                start,
   input  logic                abort,
   input  logic                s_valid,
   input  logic [BITWIDTH-1:0] s_data,
   output logic                s_ready,
   output logic                f_process_enable,
   output logic                f_data_in_valid,
   output logic [BITWIDTH-1:0] f_data_in,
   output logic                f_weight_in_valid,
   output logic [3:0]          f_weight_addr,
   output logic [BITWIDTH-1:0] f_weight_data,
   output logic                f_int,
   output logic                busy,
   output logic                frame_done,
   output logic                irq,
   input  logic                irq_clr,
   output logic [15:0]         frame_cnt
);

   localparam int NPIX  = COLS * ROWS;
   localparam int PIX_W = cnt_w(NPIX);
   localparam int GAP_W = cnt_w(PIX_GAP + 1);
   localparam int DRN_W = cnt_w(DRAIN_CYC);

   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);
   localparam logic [3:0]       LD_LAST  = 4'(NUM_WEIGHTS - 1);

   state_e              state_q, state_d;
   logic [3:0]          load_cnt_q, load_cnt_d;
   logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;
   logic                f_int_q, f_int_d;
   logic                dv_q, dv_d;
   logic [BITWIDTH-1:0] din_q, din_d;
   logic                irq_q, irq_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;

   logic [BITWIDTH-1:0] wb_rd_data;
   logic                wb_mode, wb_dirty;
   logic                accept, load_entry;

   filter2d_ctrl_wbank #(.BITWIDTH(BITWIDTH)) u_wbank (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .rd_addr   (load_cnt_q),
      .clr_dirty (load_entry),
      .rd_data   (wb_rd_data),
      .mode      (wb_mode),
      .dirty     (wb_dirty)
   );

`ifndef FILTER2D_CTRL_CONT_EN
   logic unused_dirty;
   assign unused_dirty = wb_dirty;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         load_cnt_q  <= '0;
         pix_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         drain_cnt_q <= '0;
         f_int_q     <= 1'b0;
         dv_q        <= 1'b0;
         din_q       <= '0;
         irq_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         f_int_q     <= f_int_d;
         dv_q        <= dv_d;
         din_q       <= din_d;
         irq_q       <= irq_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   if (load_cnt_q == LD_LAST) state_d = ST_STREAM;
            ST_STREAM: if (accept && pix_cnt_q == PIX_LAST) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt_q == DRN_LAST) state_d = ST_DONE;
`ifdef FILTER2D_CTRL_CONT_EN
            ST_DONE:   state_d = wb_dirty ? ST_LOAD : ST_STREAM;
`else
            ST_DONE:   state_d = ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // The abort cycle refuses pixels so an aborted frame consumes nothing extra.
   always_comb begin
      s_ready           = (state_q == ST_STREAM) && (gap_cnt_q == '0) && !abort;
      f_process_enable  = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
      f_weight_in_valid = (state_q == ST_LOAD);
      f_weight_addr     = (state_q == ST_LOAD) ? load_cnt_q : 4'd0;
      f_weight_data     = (state_q == ST_LOAD) ? wb_rd_data : '0;
      busy              = (state_q != ST_IDLE);
      frame_done        = (state_q == ST_DONE) && !abort;
   end

   assign accept     = s_valid && s_ready;
   assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);

   always_comb begin
      load_cnt_d  = '0;
      pix_cnt_d   = pix_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      drain_cnt_d = '0;
      if (state_q == ST_LOAD && load_cnt_q != LD_LAST) load_cnt_d = load_cnt_q + 4'd1;
      if (state_q == ST_DRAIN && drain_cnt_q != DRN_LAST) drain_cnt_d = drain_cnt_q + DRN_W'(1);
      if (state_q == ST_DONE) pix_cnt_d = '0;
      if (accept) begin
         pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PIX_W'(1);
         gap_cnt_d = GAP_W'(PIX_GAP);
      end else if (gap_cnt_q != '0) begin
         gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      if (abort) begin
         load_cnt_d  = '0;
         pix_cnt_d   = '0;
         gap_cnt_d   = '0;
         drain_cnt_d = '0;
      end
   end

   always_comb begin
      f_int_d     = load_entry ? wb_mode : f_int_q;
      dv_d        = accept;
      din_d       = accept ? s_data : din_q;
      irq_d       = frame_done ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
      frame_cnt_d = frame_cnt_q + 16'(frame_done);
   end

   assign f_int           = f_int_q;
   assign f_data_in_valid = dv_q;
   assign f_data_in       = din_q;
   assign irq             = irq_q;
   assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_filter2d_ctrl.sv
// Directed bench for filter2d_ctrl (default build): a back-to-back instance and a PIX_GAP=2
// instance share stimulus; a per-instance queue scoreboards pixels through to the PE port.
module tb_filter2d_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we, start, abort, s_valid, irq_clr;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_wdata, s_data;

   logic       o0_rdy, o0_pe, o0_dv, o0_wv, o0_int, o0_busy, o0_done, o0_irq;
   logic [7:0] o0_din, o0_wd;
   logic [3:0] o0_wa;
   logic [15:0] o0_fc;
   logic       og_rdy, og_pe, og_dv, og_wv, og_int, og_busy, og_done, og_irq;
   logic [7:0] og_din, og_wd;
   logic [3:0] og_wa;
   logic [15:0] og_fc;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] q0[$];
   logic [7:0] qg[$];

   always #5 clk = ~clk;

   filter2d_ctrl #(.BITWIDTH(8), .COLS(4), .ROWS(3), .DRAIN_CYC(6), .PIX_GAP(0)) u0 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(o0_rdy),
      .f_process_enable(o0_pe), .f_data_in_valid(o0_dv), .f_data_in(o0_din),
      .f_weight_in_valid(o0_wv), .f_weight_addr(o0_wa), .f_weight_data(o0_wd), .f_int(o0_int),
      .busy(o0_busy), .frame_done(o0_done), .irq(o0_irq), .irq_clr(irq_clr), .frame_cnt(o0_fc)
   );

   filter2d_ctrl #(.BITWIDTH(8), .COLS(4), .ROWS(3), .DRAIN_CYC(6), .PIX_GAP(2)) ug (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(og_rdy),
      .f_process_enable(og_pe), .f_data_in_valid(og_dv), .f_data_in(og_din),
      .f_weight_in_valid(og_wv), .f_weight_addr(og_wa), .f_weight_data(og_wd), .f_int(og_int),
      .busy(og_busy), .frame_done(og_done), .irq(og_irq), .irq_clr(irq_clr), .frame_cnt(og_fc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      s_data = s_data + 8'd7;
   endtask

   // Accepted pixels become the expected PE data one cycle later.
   always @(posedge clk) begin
      if (rst && s_valid && o0_rdy) q0.push_back(s_data);
      if (rst && s_valid && og_rdy) qg.push_back(s_data);
   end

   always @(negedge clk) begin
      if (o0_dv) begin
         if (q0.size() == 0) chk("sb0_underflow", 32'd1, 32'd0);
         else chk("sb0_data", {24'd0, o0_din}, {24'd0, q0.pop_front()});
      end
      if (og_dv) begin
         if (qg.size() == 0) chk("sbg_underflow", 32'd1, 32'd0);
         else chk("sbg_data", {24'd0, og_din}, {24'd0, qg.pop_front()});
      end
   end

   initial begin
      int acc, c;
      logic seen;
      rst = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; start = 0; abort = 0;
      s_valid = 0; irq_clr = 0; s_data = 8'h10;
      tick(); tick();
      chk("rst_busy", o0_busy, 0);
      chk("rst_ready", o0_rdy, 0);
      chk("rst_pe", o0_pe, 0);
      chk("rst_dv", o0_dv, 0);
      chk("rst_wv", o0_wv, 0);
      chk("rst_wa", o0_wa, 0);
      chk("rst_wd", o0_wd, 0);
      chk("rst_int", o0_int, 0);
      chk("rst_done", o0_done, 0);
      chk("rst_irq", o0_irq, 0);
      chk("rst_fcnt", o0_fc, 0);
      rst = 1'b1;

      for (int k = 0; k < 9; k++) begin
         tick(); cfg_we = 1; cfg_addr = 4'(k); cfg_wdata = 8'(k + 1);
      end
      tick(); cfg_addr = 4'd9; cfg_wdata = 8'd1;
      tick(); cfg_we = 0; s_valid = 1; start = 1;
      tick(); start = 0;

      // LOAD replays weights 1..9 with mode bit 1
      for (int k = 0; k < 9; k++) begin
         chk("load_wv", o0_wv, 1);
         chk("load_wa", o0_wa, k);
         chk("load_wd", o0_wd, k + 1);
         chk("load_int", o0_int, 1);
         chk("load_rdy", o0_rdy, 0);
         tick();
      end

      // Frame 1: j counts negedges from first STREAM cycle
      for (int j = 0; j < 45; j++) begin
         chk("f1_rdy0", o0_rdy, j < 12);
         chk("f1_rdyg", og_rdy, (j <= 33) && (j % 3 == 0));
         chk("f1_dv0", o0_dv, (j >= 1) && (j <= 12));
         chk("f1_dvg", og_dv, (j >= 1) && (j <= 34) && ((j - 1) % 3 == 0));
         chk("f1_pe0", o0_pe, j < 18);
         chk("f1_busy0", o0_busy, j < 19);
         chk("f1_done0", o0_done, j == 18);
         chk("f1_doneg", og_done, j == 40);
         chk("f1_irq0", o0_irq, j == 19);
         chk("f1_irqg", og_irq, j >= 41);
         chk("f1_fcnt0", o0_fc, (j >= 19) ? 1 : 0);
         chk("f1_fcntg", og_fc, (j >= 41) ? 1 : 0);
         chk("f1_wv0", o0_wv, 0);
         chk("f1_int0", o0_int, 1);
         cfg_we = (j >= 5 && j <= 7);
         cfg_addr = (j == 7) ? 4'd12 : 4'd3;
         cfg_wdata = (j == 7) ? 8'hAA : 8'h44;
         irq_clr = (j == 18 || j == 19);
         tick();
      end
      cfg_we = 0; irq_clr = 0;

      // Frame 2: new weight 3 visible, addr 12 write ignored; aborted after 5 accepts
      tick(); start = 1;
      tick(); start = 0;
      for (int k = 0; k < 9; k++) begin
         chk("load2_wa", o0_wa, k);
         chk("load2_wd", o0_wd, (k == 3) ? 8'h44 : k + 1);
         tick();
      end
      for (int j = 0; j < 5; j++) begin
         chk("f2_rdy", o0_rdy, 1);
         if (j == 3) chk("f2_int_held", o0_int, 1);
         cfg_we = (j == 2); cfg_addr = 4'd9; cfg_wdata = 8'd0;
         tick();
      end
      chk("f2_dv_pre_abort", o0_dv, 1);
      abort = 1;
      tick(); abort = 0;
      chk("abort_busy", o0_busy, 0);
      chk("abort_rdy", o0_rdy, 0);
      chk("abort_pe", o0_pe, 0);
      chk("abort_dv", o0_dv, 0);
      for (int j = 0; j < 10; j++) begin
         chk("abort_no_done", o0_done, 0);
         chk("abort_fcnt", o0_fc, 1);
         tick();
      end
      start = 1; abort = 1;
      tick(); start = 0; abort = 0;
      chk("start_abort_idle", o0_busy, 0);

      // Frame 3: full restart, start mid-stream ignored, mode now 0
      start = 1;
      tick(); start = 0;
      chk("f3_int", o0_int, 0);
      acc = 0; seen = 0; c = 0;
      while (!seen && c < 200) begin
         if (o0_done) seen = 1;
         else begin
            if (s_valid && o0_rdy) acc++;
            start = (c == 15);
            tick();
            c++;
         end
      end
      start = 0;
      chk("f3_done_seen", seen, 1);
      chk("f3_latency", c, 27);
      chk("f3_accepts", acc, 12);
      tick();
      chk("f3_fcnt", o0_fc, 2);
      chk("f3_irq", o0_irq, 1);
      chk("f3_idle", o0_busy, 0);
      c = 0;
      while (og_busy && c < 200) begin
         tick();
         c++;
      end
      chk("g_idle", og_busy, 0);
      s_valid = 0;
      tick(); tick();
      chk("sb0_drained", q0.size(), 0);
      chk("sbg_drained", qg.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
